ps2_host_tx: RTL and testbench

Host-to-device transmitter for the PS/2 keyboard port. It sends one command byte, such as 0xED (set LEDs), to the keyboard using the PS/2 inhibit/request-to-send sequence, then checks the device acknowledge. It sits beside the receive path, shares the synchronized kb_clk/kb_data inputs with it, and drives both PS/2 lines open-drain through output-enable signals.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_clk_fall.sv | 33 +++
 rtl/ps2_host_tx.sv | 198 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, frame constants and command bytes
//
// Purpose: common definitions for the PS/2 host transmit and receive paths.
// Contents: ps2_tx_state_t (host transmit FSM states), PS2_FRAME_FALLS,
//           command byte constants and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    PS2_TX_IDLE,
    PS2_TX_INHIBIT,
    PS2_TX_RTS,
    PS2_TX_SHIFT,
    PS2_TX_ACK,
    PS2_TX_WAIT_IDLE
  } ps2_tx_state_t;

  // Falling kb_clk edges in one host-to-device frame: 10 bits plus the ack slot.
  localparam int unsigned PS2_FRAME_FALLS = 11;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

  // Parity bit that makes the total count of ones in data+parity odd.
  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_clk_fall.sv
// rtl/ps2_clk_fall.sv - falling-edge detector for the synchronized kb_clk
//
// Purpose: flags a high-to-low transition of kb_clk using two clk-domain
//          registers; no logic is clocked by kb_clk itself.
// Ports:
//   clk           in  system clock
//   rst           in  asynchronous active-high reset
//   kb_clk_sync_i in  kb_clk already synchronized to clk
//   fall_o        out one-cycle flag, kb_clk went from 1 to 0
module ps2_clk_fall (
  input  logic clk,
  input  logic rst,
  input  logic kb_clk_sync_i,
  output logic fall_o
);

  logic now_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      now_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      now_q  <= kb_clk_sync_i;
      prev_q <= now_q;
    end
  end

  // Clearing both registers to 0 means no spurious fall can follow reset.
  assign fall_o = prev_q & ~now_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
//
// Purpose: sends one command byte to the device using the inhibit /
//          request-to-send sequence and checks the device acknowledge.
//          PS/2 lines are driven open-drain through output enables.
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   kb_clk_sync_i       kb_clk synchronized to clk
//   kb_data_sync_i      kb_data synchronized to clk
//   tx_data_i/valid_i   command byte and send request
//   tx_ready_o          transfer accepted when tx_valid_i && tx_ready_o
//   kb_clk_oe_o         1 = pull kb_clk low
//   kb_data_oe_o        1 = pull kb_data low
//   busy_o              transfer in progress
//   tx_done_o, tx_err_o one-cycle outcome pulses (ack / nack or timeout)
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kb_clk_sync_i,
  input  logic       kb_data_sync_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       kb_clk_oe_o,
  output logic       kb_data_oe_o,
  output logic       busy_o,
  output logic       tx_done_o,
  output logic       tx_err_o
);

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       FALLS_MAX   = 4'(PS2_FRAME_FALLS);
  localparam logic [3:0]       FALLS_DATA  = 4'(PS2_FRAME_FALLS - 3);
  localparam logic [3:0]       FALLS_PAR   = 4'(PS2_FRAME_FALLS - 3);
  localparam logic [3:0]       FALLS_STOP  = 4'(PS2_FRAME_FALLS - 2);

  ps2_tx_state_t    state_q, state_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [3:0]       falls_q, falls_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

  logic fall;
  logic accept;
  logic in_frame;
  logic lines_idle;
  logic inh_last;
  logic timeout;

  ps2_clk_fall u_clk_fall (
    .clk           (clk),
    .rst           (rst),
    .kb_clk_sync_i (kb_clk_sync_i),
    .fall_o        (fall)
  );

  // Ready is held low during the outcome pulse so a new request is only
  // taken once the previous result has been reported.
  assign tx_ready_o   = (state_q == PS2_TX_IDLE) && !done_q && !err_q;
  assign busy_o       = (state_q != PS2_TX_IDLE);
  assign kb_clk_oe_o  = clk_oe_q;
  assign kb_data_oe_o = data_oe_q;
  assign tx_done_o    = done_q;
  assign tx_err_o     = err_q;

  assign accept     = tx_valid_i && tx_ready_o;
  assign in_frame   = (state_q == PS2_TX_RTS) || (state_q == PS2_TX_SHIFT) ||
                      (state_q == PS2_TX_ACK) || (state_q == PS2_TX_WAIT_IDLE);
  assign lines_idle = kb_clk_sync_i && kb_data_sync_i;
  assign inh_last   = (inh_cnt_q == INH_LAST);
  // A successful finish in WAIT_IDLE wins over a timeout landing on the same cycle.
  assign timeout    = in_frame && !fall && (to_cnt_q == TO_LAST) &&
                      !((state_q == PS2_TX_WAIT_IDLE) && lines_idle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PS2_TX_IDLE;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      falls_q   <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      falls_q   <= falls_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = PS2_TX_IDLE;
    end else begin
      unique case (state_q)
        PS2_TX_IDLE:      if (accept) state_d = PS2_TX_INHIBIT;
        PS2_TX_INHIBIT:   if (inh_last) state_d = PS2_TX_RTS;
        PS2_TX_RTS:       state_d = PS2_TX_SHIFT;
        PS2_TX_SHIFT:     if (fall && (falls_q == FALLS_STOP)) state_d = PS2_TX_ACK;
        PS2_TX_ACK:       if (fall) state_d = kb_data_sync_i ? PS2_TX_IDLE : PS2_TX_WAIT_IDLE;
        PS2_TX_WAIT_IDLE: if (lines_idle) state_d = PS2_TX_IDLE;
        default:          state_d = PS2_TX_IDLE;
      endcase
    end
  end

  always_comb begin
    clk_oe_d  = 1'b0;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    shift_d   = shift_q;
    parity_d  = parity_q;
    falls_d   = falls_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;

    if (in_frame) begin
      to_cnt_d = fall ? '0 : to_cnt_q + 1'b1;
      if (fall && (falls_q != FALLS_MAX)) falls_d = falls_q + 4'd1;
    end

    unique case (state_q)
      PS2_TX_IDLE: begin
        data_oe_d = 1'b0;
        if (accept) begin
          shift_d   = tx_data_i;
          parity_d  = ps2_odd_parity(tx_data_i);
          falls_d   = '0;
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
        end
      end
      PS2_TX_INHIBIT: begin
        if (inh_last) begin
          // Release kb_clk with kb_data already low: the start bit.
          data_oe_d = 1'b1;
          to_cnt_d  = '0;
        end else begin
          clk_oe_d  = 1'b1;
          inh_cnt_d = inh_cnt_q + 1'b1;
          data_oe_d = (inh_cnt_q == INH_PRE);
        end
      end
      PS2_TX_SHIFT: begin
        if (fall) begin
          if (falls_q < FALLS_DATA) begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end else if (falls_q == FALLS_PAR) begin
            data_oe_d = ~parity_q;
          end else begin
            data_oe_d = 1'b0;
          end
        end
      end
      PS2_TX_ACK: begin
        if (fall && kb_data_sync_i) err_d = 1'b1;
      end
      PS2_TX_WAIT_IDLE: begin
        if (lines_idle) done_d = 1'b1;
      end
      default: ;
    endcase

    if (timeout) begin
      data_oe_d = 1'b0;
      err_d     = 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, kb_clk_oe, kb_data_oe, busy, tx_done, tx_err;
  logic       dev_clk_low, dev_data_low;
  logic       kb_clk_line, kb_data_line;

  int n_vec = 0;
  int n_miss = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit exp_q[$];

  assign kb_clk_line  = ~(kb_clk_oe | dev_clk_low);
  assign kb_data_line = ~(kb_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(200)) dut (
    .clk            (clk),
    .rst            (rst),
    .kb_clk_sync_i  (kb_clk_line),
    .kb_data_sync_i (kb_data_line),
    .tx_data_i      (tx_data),
    .tx_valid_i     (tx_valid),
    .tx_ready_o     (tx_ready),
    .kb_clk_oe_o    (kb_clk_oe),
    .kb_data_oe_o   (kb_data_oe),
    .busy_o         (busy),
    .tx_done_o      (tx_done),
    .tx_err_o       (tx_err)
  );

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] b);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    exp_q.push_back(($countones(b) % 2) == 0);
    exp_q.push_back(1'b1);
  endtask

  task automatic sb_sample(input string tag);
    if (exp_q.size() == 0) check({tag, "_underflow"}, 32'(exp_q.size()), 1);
    else check(tag, 32'(kb_data_line), 32'(exp_q.pop_front()));
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    check("ready_before", 32'(tx_ready), 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("clk_oe_after_accept", 32'(kb_clk_oe), 1);
    check("busy_after_accept", 32'(busy), 1);
  endtask

  // Returns at the first negedge with kb_clk released (RTS cycle).
  task automatic wait_rts(output int hi, output logic last_doe);
    hi = 0;
    last_doe = 1'b0;
    while (kb_clk_oe && hi < 1000) begin
      last_doe = kb_data_oe;
      hi++;
      @(negedge clk);
    end
  endtask

  // Device clock pulses; bit n is read at the end of the low half after fall n.
  task automatic dev_frame(input int nclk, input bit ack);
    for (int i = 1; i <= nclk; i++) begin
      @(negedge clk);
      if (i == 1) sb_sample("start_bit");
      dev_clk_low = 1'b1;
      if (i == 11 && ack) dev_data_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (i <= 10) sb_sample("frame_bit");
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic run_ok(input logic [7:0] b);
    int hi;
    logic ld;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(b);
    push_frame(b);
    wait_rts(hi, ld);
    check("inhibit_len", 32'(hi), 20);
    check("inhibit_data_last", 32'(ld), 1);
    dev_frame(11, 1'b1);
    check("done_pulses", 32'(done_cnt - d0), 1);
    check("err_pulses", 32'(err_cnt - e0), 0);
    check("ready_after", 32'(tx_ready), 1);
    check("data_oe_after", 32'(kb_data_oe), 0);
    check("sb_left", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int hi, steps, e0, d0;
    logic ld;
    rst = 1'b1;
    tx_data = '0;
    tx_valid = 1'b0;
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(tx_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_oe", 32'({kb_clk_oe, kb_data_oe}), 0);
    check("rst_pulses", 32'({tx_done, tx_err}), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Set-LED command acknowledged, then an all-zero byte.
    run_ok(PS2_CMD_SET_LED);
    run_ok(8'h00);

    // NACK: device leaves kb_data high on fall 11.
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(PS2_CMD_RESET);
    push_frame(PS2_CMD_RESET);
    wait_rts(hi, ld);
    check("nack_inhibit_len", 32'(hi), 20);
    dev_frame(10, 1'b0);
    @(negedge clk);
    dev_clk_low = 1'b1;
    steps = 0;
    while (!tx_err && steps < 20) begin
      @(negedge clk);
      steps++;
    end
    check("nack_err_seen", 32'(tx_err), 1);
    check("nack_ready_in_pulse", 32'(tx_ready), 0);
    check("nack_busy", 32'(busy), 0);
    @(negedge clk);
    check("nack_ready_next", 32'(tx_ready), 1);
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (HALF) @(negedge clk);
    check("nack_err_pulses", 32'(err_cnt - e0), 1);
    check("nack_done_pulses", 32'(done_cnt - d0), 0);
    check("nack_sb_left", 32'(exp_q.size()), 0);

    // Timeout: device never clocks after RTS.
    e0 = err_cnt;
    start_tx(8'hF4);
    wait_rts(hi, ld);
    steps = 0;
    while (!tx_err && steps < 1000) begin
      @(negedge clk);
      steps++;
    end
    check("timeout_cycles", 32'(steps), 200);
    check("timeout_oe", 32'({kb_clk_oe, kb_data_oe}), 0);
    @(negedge clk);
    check("timeout_err_pulses", 32'(err_cnt - e0), 1);
    check("timeout_ready", 32'(tx_ready), 1);

    // Reset in the middle of a frame, after fall 4 (data bit 3 = 0 is driven).
    start_tx(8'hA5);
    push_frame(8'hA5);
    wait_rts(hi, ld);
    dev_frame(4, 1'b1);
    check("mid_data_oe", 32'(kb_data_oe), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_oe", 32'({kb_clk_oe, kb_data_oe}), 0);
    check("rst_mid_ready", 32'(tx_ready), 1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    run_ok(8'hA5);

    // Request while busy is dropped; the set-LED frame is unchanged.
    fork
      run_ok(PS2_CMD_SET_LED);
      begin
        repeat (200) @(negedge clk);
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    check("ignored_busy", 32'(busy), 0);
    check("ignored_clk_oe", 32'(kb_clk_oe), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
